// File: rtl/feeder_pkg.sv
// Shared definitions for the serial word feeder and its test environment.
//   - feeder_state_e : FSM state encoding (ST_IDLE / ST_SHIFT)
//   - FEEDER_WIDTH_DEFAULT : default parallel word width
//   - FEEDER_IDLE_BIT : bit driven on w when no word is in flight; the
//     downstream detector environment uses the same constant
package feeder_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } feeder_state_e;

    localparam int   FEEDER_WIDTH_DEFAULT = 8;
    localparam logic FEEDER_IDLE_BIT      = 1'b0;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in / serial-out shift register with a bits-remaining counter.
//   clk_i, rst_i     : clock, asynchronous active-high reset
//   load_i           : load load_data_i, cnt = WIDTH (has priority over shift)
//   load_data_i      : word to load
//   shift_i          : shift one position toward the output end, cnt - 1
//   bit_out_o        : bit currently at the output end of the register
//   last_o           : exactly one bit remains (cnt == 1)
module piso_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             shift_i,
    output logic             bit_out_o,
    output logic             last_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (load_i) begin
            shreg_d = load_data_i;
            cnt_d   = CNT_W'(WIDTH);
        end else if (shift_i) begin
            // Vacated position is zero-filled.
            if (MSB_FIRST) shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            else           shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bit_out_o = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    assign last_o    = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/serial_word_feeder.sv
// Serializes parallel words (valid/ready) onto a single-bit stream w.
//   clk, reset  : clock, asynchronous active-high reset
//   data_in     : parallel word, sampled only on a transfer edge
//   data_valid  : data_in holds a word
//   data_ready  : a word can be accepted (hold buffer empty, not in reset)
//   w           : serial bit, IDLE_BIT when nothing is shifting
//   busy        : a word is shifting or waiting in the hold buffer
//   word_done   : the last bit of a word is on w this cycle
// A one-word hold buffer lets the next word start on the edge right after
// the previous word's last bit, so continuous traffic has no gap bits.
module serial_word_feeder
    import feeder_pkg::*;
#(
    parameter int   WIDTH     = FEEDER_WIDTH_DEFAULT,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = FEEDER_IDLE_BIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             w,
    output logic             busy,
    output logic             word_done
);

    feeder_state_e    state_q;
    logic [WIDTH-1:0] hold_q;
    logic             hold_full_q;

    logic             xfer;
    logic             last;
    logic             bit_out;
    logic             load;
    logic             shift;
    logic [WIDTH-1:0] load_data;

    assign data_ready = !hold_full_q && !reset;
    assign xfer       = data_valid && data_ready;

    // Reload on the last-bit edge either from hold or directly from the
    // input (bypass). Transfer and hold drain never coincide because
    // data_ready is low while hold is full.
    always_comb begin
        load      = 1'b0;
        load_data = data_in;
        if (state_q == ST_IDLE) begin
            load = xfer;
        end else if (last) begin
            load = hold_full_q || xfer;
            if (hold_full_q) load_data = hold_q;
        end
        shift = (state_q == ST_SHIFT) && !load;
    end

    piso_shift_reg #(
        .WIDTH    (WIDTH),
        .MSB_FIRST(MSB_FIRST)
    ) u_piso (
        .clk_i      (clk),
        .rst_i      (reset),
        .load_i     (load),
        .load_data_i(load_data),
        .shift_i    (shift),
        .bit_out_o  (bit_out),
        .last_o     (last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (xfer) state_q <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (last) begin
                        if (!hold_full_q && !xfer) state_q <= ST_IDLE;
                        hold_full_q <= 1'b0;
                    end else if (xfer) begin
                        hold_q      <= data_in;
                        hold_full_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign w         = (state_q == ST_SHIFT) ? bit_out : IDLE_BIT;
    assign busy      = (state_q == ST_SHIFT) || hold_full_q;
    assign word_done = (state_q == ST_SHIFT) && last;

endmodule
